// File: rtl/div_by_3_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | div_by_3_checker: unsigned mod-3 residue via base-4 digit-sum tree      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module div_by_3_checker #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              in_valid,
  output logic              divisibility,
  output logic [1:0]        remainder,
  output logic              div_q,
  output logic [1:0]        rem_q,
  output logic              valid_q
);

  localparam int PAD_W  = DATA_W + (DATA_W & 1);
  localparam int NDIG   = PAD_W >> 1;
  localparam int LEVELS = (NDIG > 1) ? $clog2(NDIG) : 0;
  localparam int LEAVES = 1 << LEVELS;

  logic [PAD_W-1:0] data_ext;

  generate
    if (PAD_W != DATA_W) begin : g_pad_odd
      assign data_ext = {1'b0, data};
    end else begin : g_pad_even
      assign data_ext = data;
    end
  endgenerate

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Pairwise reduction, halving the live residue count each level; unused leaves are 0.
  always_comb begin
    logic [1:0] acc [LEAVES];
    logic [1:0] digit;
    for (int j = 0; j < LEAVES; j++) begin
      acc[j] = 2'd0;
      if (j < NDIG) begin
        digit  = data_ext[2*j +: 2];
        acc[j] = (digit == 2'd3) ? 2'd0 : digit;
      end
    end
    for (int w = LEAVES >> 1; w > 0; w = w >> 1) begin
      for (int k = 0; k < w; k++) begin
        acc[k] = add_mod3(acc[2*k], acc[2*k+1]);
      end
    end
    remainder    = acc[0];
    divisibility = (acc[0] == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 1'b0;
      rem_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (in_valid) begin
      div_q   <= divisibility;
      rem_q   <= remainder;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_by_3_checker.sv
`default_nettype none
// Directed bench for div_by_3_checker at widths 16, 1, 7 and 64.
module tb_div_by_3_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] data16 = '0;
  logic        div16, div_q16, valid_q16;
  logic [1:0]  rem16, rem_q16;

  logic        data1 = 1'b0;
  logic        div1, div_q1, valid_q1;
  logic [1:0]  rem1, rem_q1;

  logic [6:0]  data7 = '0;
  logic        div7, div_q7, valid_q7;
  logic [1:0]  rem7, rem_q7;

  logic [63:0] data64 = '0;
  logic        div64, div_q64, valid_q64;
  logic [1:0]  rem64, rem_q64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_by_3_checker #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .data(data16), .in_valid(in_valid),
    .divisibility(div16), .remainder(rem16),
    .div_q(div_q16), .rem_q(rem_q16), .valid_q(valid_q16)
  );
  div_by_3_checker #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .in_valid(1'b0),
    .divisibility(div1), .remainder(rem1),
    .div_q(div_q1), .rem_q(rem_q1), .valid_q(valid_q1)
  );
  div_by_3_checker #(.DATA_W(7)) dut7 (
    .clk(clk), .rst(rst), .data(data7), .in_valid(1'b0),
    .divisibility(div7), .remainder(rem7),
    .div_q(div_q7), .rem_q(rem_q7), .valid_q(valid_q7)
  );
  div_by_3_checker #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .data(data64), .in_valid(1'b0),
    .divisibility(div64), .remainder(rem64),
    .div_q(div_q64), .rem_q(rem_q64), .valid_q(valid_q64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check16(input logic [15:0] v, input logic d, input logic [1:0] r);
    data16 = v;
    #1;
    check($sformatf("div16[%0d]", v), 64'(div16), 64'(d));
    check($sformatf("rem16[%0d]", v), 64'(rem16), 64'(r));
  endtask

  initial begin
    logic [63:0] w;
    logic [15:0] v;

    // Reset held two cycles.
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_div_q", 64'(div_q16), 64'd0);
    check("rst_rem_q", 64'(rem_q16), 64'd0);
    check("rst_valid_q", 64'(valid_q16), 64'd0);
    rst = 1'b0;

    // Corner values.
    check16(16'd0,     1'b1, 2'd0);
    check16(16'd1,     1'b0, 2'd1);
    check16(16'd2,     1'b0, 2'd2);
    check16(16'd3,     1'b1, 2'd0);
    check16(16'd65534, 1'b0, 2'd2);
    check16(16'd65535, 1'b1, 2'd0);

    // Random sweep at 16 bits against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom);
      check16(v, (v % 3) == 0, 2'(v % 3));
    end

    // Registered path: stream 9, 10, 11.
    @(posedge clk);
    #1;
    data16 = 16'd9;  in_valid = 1'b1;
    @(posedge clk); #1;
    check("s9_valid_q", 64'(valid_q16), 64'd1);
    check("s9_div_q",   64'(div_q16),   64'd1);
    check("s9_rem_q",   64'(rem_q16),   64'd0);
    data16 = 16'd10;
    @(posedge clk); #1;
    check("s10_valid_q", 64'(valid_q16), 64'd1);
    check("s10_div_q",   64'(div_q16),   64'd0);
    check("s10_rem_q",   64'(rem_q16),   64'd1);
    data16 = 16'd11;
    @(posedge clk); #1;
    check("s11_valid_q", 64'(valid_q16), 64'd1);
    check("s11_div_q",   64'(div_q16),   64'd0);
    check("s11_rem_q",   64'(rem_q16),   64'd2);
    in_valid = 1'b0;
    data16 = 16'd12;
    repeat (2) begin
      @(posedge clk); #1;
      check("hold_valid_q", 64'(valid_q16), 64'd0);
      check("hold_div_q",   64'(div_q16),   64'd0);
      check("hold_rem_q",   64'(rem_q16),   64'd2);
    end

    // Reset mid-stream drops the presented word.
    data16 = 16'd6; in_valid = 1'b1; rst = 1'b1;
    #1;
    check("midrst_comb_div", 64'(div16), 64'd1);
    check("midrst_comb_rem", 64'(rem16), 64'd0);
    @(posedge clk); #1;
    check("midrst_valid_q", 64'(valid_q16), 64'd0);
    check("midrst_div_q",   64'(div_q16),   64'd0);
    check("midrst_rem_q",   64'(rem_q16),   64'd0);
    rst = 1'b0; in_valid = 1'b0;

    // DATA_W = 1.
    data1 = 1'b0; #1;
    check("w1_div_0", 64'(div1), 64'd1);
    check("w1_rem_0", 64'(rem1), 64'd0);
    data1 = 1'b1; #1;
    check("w1_div_1", 64'(div1), 64'd0);
    check("w1_rem_1", 64'(rem1), 64'd1);

    // DATA_W = 7 exhaustive.
    for (int i = 0; i < 128; i++) begin
      data7 = 7'(i); #1;
      check($sformatf("w7_div[%0d]", i), 64'(div7), 64'((i % 3) == 0));
      check($sformatf("w7_rem[%0d]", i), 64'(rem7), 64'(i % 3));
    end

    // DATA_W = 64: all-ones then random.
    data64 = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check("w64_ones_div", 64'(div64), 64'd1);
    check("w64_ones_rem", 64'(rem64), 64'd0);
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom, $urandom};
      data64 = w; #1;
      check($sformatf("w64_div[%0h]", w), 64'(div64), 64'((w % 64'd3) == 0));
      check($sformatf("w64_rem[%0h]", w), 64'(rem64), w % 64'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
